// File: rtl/vga_pkg.sv
// Shared constants and helpers for the tile-based VGA pixel pipeline.
// Colours are RGB 3:3:2, matching the DAC's 8-bit input.
package vga_pkg;
    localparam int H_ACTIVE       = 640;
    localparam int V_ACTIVE       = 480;
    localparam int TILE_SHIFT     = 3;
    localparam int COLS           = H_ACTIVE >> TILE_SHIFT;
    localparam int ROWS           = V_ACTIVE >> TILE_SHIFT;
    localparam int RENDER_LATENCY = 3;
    localparam int MAP_AW         = 13;
    localparam int GLY_AW         = 11;
    localparam int BLINK_B        = 4;

    localparam logic [7:0] RGB_BLACK = 8'h00;
    localparam logic [7:0] RGB_WHITE = 8'hFF;
    localparam logic [7:0] RGB_RED   = 8'hE0;
    localparam logic [7:0] RGB_GREEN = 8'h1C;
    localparam logic [7:0] RGB_BLUE  = 8'h03;

    typedef struct packed {
        logic bright;
        logic hsync;
        logic vsync;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{bright: 1'b0, hsync: 1'b1, vsync: 1'b1};

    // row*80 + col as shift-adds; only valid for an 80-column map.
    function automatic logic [MAP_AW-1:0] map_index(input logic [7:0] r, input logic [7:0] c);
        return (MAP_AW'(r) << 6) + (MAP_AW'(r) << 4) + MAP_AW'(c);
    endfunction
endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register; every stage reloads INIT on clear.
module vga_delay_line #(
    parameter int               WIDTH = 3,
    parameter int               DEPTH = 3,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] stage_reg;
            logic [WIDTH-1:0] stage_next;
            if (gi == 0) begin : g_head
                assign stage_next = din;
            end else begin : g_tail
                assign stage_next = g_stage[gi-1].stage_reg;
            end
            always_ff @(posedge clk) begin
                if (clear) begin
                    stage_reg <= INIT;
                end else if (enable) begin
                    stage_reg <= stage_next;
                end
            end
        end
    endgenerate

    assign dout = g_stage[DEPTH-1].stage_reg;
endmodule

// File: rtl/vga_tile_renderer.sv
// Renders an 80x60 grid of 8x8 glyph tiles with a blinking inverse cursor.
// Four enable-gated stages: map address, glyph address, pixel pick, colour/sync out.
module vga_tile_renderer
    import vga_pkg::*;
#(
    parameter int P_COLS    = COLS,
    parameter int P_ROWS    = ROWS,
    parameter int P_MAP_AW  = MAP_AW,
    parameter int P_GLY_AW  = GLY_AW,
    parameter int P_BLINK_B = BLINK_B
) (
    input  logic                clk,
    input  logic                clear,
    input  logic                enable,
    input  logic [10:0]         hCount,
    input  logic [10:0]         vCount,
    input  logic                bright,
    input  logic                hSync_in,
    input  logic                vSync_in,
    output logic [P_MAP_AW-1:0] tile_addr,
    input  logic [7:0]          tile_data,
    output logic [P_GLY_AW-1:0] glyph_addr,
    input  logic [7:0]          glyph_data,
    input  logic                color_we,
    input  logic [15:0]         color_in,
    input  logic                cursor_en,
    input  logic [6:0]          cursor_col,
    input  logic [5:0]          cursor_row,
    output logic [7:0]          rgb,
    output logic                hSync,
    output logic                vSync
);
    logic [7:0] tile_col;
    logic [7:0] tile_row;
    logic       hit_next;

    logic [P_MAP_AW-1:0] tile_addr_reg;
    logic [P_GLY_AW-1:0] glyph_addr_reg;
    logic [2:0]          col3_s0_reg, col3_s1_reg, row3_s0_reg;
    logic                hit_s0_reg, hit_s1_reg, hit_s2_reg, pix_s2_reg;
    logic [7:0]          rgb_reg;
    logic                hsync_reg, vsync_reg;
    logic [7:0]          fg_reg, bg_reg;
    logic [7:0]          frame_cnt_reg;
    logic                vsync_prev_reg;
    logic                blink;
    sync_t               sync_s2;

    assign tile_col = hCount[10:TILE_SHIFT];
    assign tile_row = vCount[10:TILE_SHIFT];
    assign blink    = frame_cnt_reg[P_BLINK_B];

    // Range guard makes an out-of-range cursor inert even if the compare width allows a match.
    assign hit_next = cursor_en
                   && (32'(cursor_col) < P_COLS) && (32'(cursor_row) < P_ROWS)
                   && (tile_col == {1'b0, cursor_col})
                   && (tile_row == {2'b00, cursor_row});

    vga_delay_line #(
        .WIDTH (3),
        .DEPTH (RENDER_LATENCY),
        .INIT  (SYNC_IDLE)
    ) u_sync_dly (
        .clk    (clk),
        .clear  (clear),
        .enable (enable),
        .din    ({bright, hSync_in, vSync_in}),
        .dout   (sync_s2)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            tile_addr_reg  <= '0;
            glyph_addr_reg <= '0;
            col3_s0_reg    <= '0;
            col3_s1_reg    <= '0;
            row3_s0_reg    <= '0;
            hit_s0_reg     <= 1'b0;
            hit_s1_reg     <= 1'b0;
            hit_s2_reg     <= 1'b0;
            pix_s2_reg     <= 1'b0;
            rgb_reg        <= RGB_BLACK;
            hsync_reg      <= 1'b1;
            vsync_reg      <= 1'b1;
        end else if (enable) begin
            tile_addr_reg  <= P_MAP_AW'(map_index(tile_row, tile_col));
            col3_s0_reg    <= hCount[2:0];
            row3_s0_reg    <= vCount[2:0];
            hit_s0_reg     <= hit_next;

            glyph_addr_reg <= P_GLY_AW'({tile_data, row3_s0_reg});
            col3_s1_reg    <= col3_s0_reg;
            hit_s1_reg     <= hit_s0_reg;

            // Bit 7 is the leftmost pixel, so the column is inverted to index it.
            pix_s2_reg     <= glyph_data[~col3_s1_reg];
            hit_s2_reg     <= hit_s1_reg;

            rgb_reg        <= !sync_s2.bright ? RGB_BLACK
                            : ((pix_s2_reg ^ (hit_s2_reg & blink)) ? fg_reg : bg_reg);
            hsync_reg      <= sync_s2.hsync;
            vsync_reg      <= sync_s2.vsync;
        end
    end

    // Colour register and frame counter run on every clk, independent of the pixel tick.
    always_ff @(posedge clk) begin
        if (clear) begin
            fg_reg         <= RGB_WHITE;
            bg_reg         <= RGB_BLACK;
            frame_cnt_reg  <= '0;
            vsync_prev_reg <= 1'b1;
        end else begin
            if (color_we) begin
                {fg_reg, bg_reg} <= color_in;
            end
            vsync_prev_reg <= vSync_in;
            if (vsync_prev_reg && !vSync_in) begin
                frame_cnt_reg <= frame_cnt_reg + 8'd1;
            end
        end
    end

    assign tile_addr  = tile_addr_reg;
    assign glyph_addr = glyph_addr_reg;
    assign rgb        = rgb_reg;
    assign hSync      = hsync_reg;
    assign vSync      = vsync_reg;
endmodule

// File: tb/tb_vga_tile_renderer.sv
// Directed bench for vga_tile_renderer: external map/glyph memories plus a pixel scoreboard.
module tb_vga_tile_renderer;
    logic        clk = 1'b0;
    logic        clear = 1'b0;
    logic        enable = 1'b0;
    logic [10:0] hCount = '0;
    logic [10:0] vCount = '0;
    logic        bright = 1'b0;
    logic        hSync_in = 1'b1;
    logic        vSync_in = 1'b1;
    logic [12:0] tile_addr;
    logic [7:0]  tile_data;
    logic [10:0] glyph_addr;
    logic [7:0]  glyph_data;
    logic        color_we = 1'b0;
    logic [15:0] color_in = '0;
    logic        cursor_en = 1'b0;
    logic [6:0]  cursor_col = '0;
    logic [5:0]  cursor_row = '0;
    logic [7:0]  rgb;
    logic        hSync;
    logic        vSync;

    int checks = 0;
    int errors = 0;
    int tick_no = 0;

    logic [7:0] tile_map  [8192];
    logic [7:0] glyph_rom [2048];

    typedef struct packed {
        logic pix;
        logic hit;
        logic bright;
        logic hs;
        logic vs;
    } sb_t;
    sb_t sb[$];

    logic [7:0] fg_m, bg_m, frame_m;

    vga_tile_renderer dut (
        .clk        (clk),
        .clear      (clear),
        .enable     (enable),
        .hCount     (hCount),
        .vCount     (vCount),
        .bright     (bright),
        .hSync_in   (hSync_in),
        .vSync_in   (vSync_in),
        .tile_addr  (tile_addr),
        .tile_data  (tile_data),
        .glyph_addr (glyph_addr),
        .glyph_data (glyph_data),
        .color_we   (color_we),
        .color_in   (color_in),
        .cursor_en  (cursor_en),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .rgb        (rgb),
        .hSync      (hSync),
        .vSync      (vSync)
    );

    always #10 clk = ~clk;

    // Synchronous external memories: data one clk after the address.
    always @(posedge clk) begin
        tile_data  <= tile_map[tile_addr];
        glyph_data <= glyph_rom[glyph_addr];
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic prefill_idle();
        sb_t e;
        e = '{pix: 1'b0, hit: 1'b0, bright: 1'b0, hs: 1'b1, vs: 1'b1};
        sb.delete();
        repeat (3) sb.push_back(e);
    endtask

    task automatic do_reset(input logic we_during);
        @(negedge clk);
        clear = 1'b1;
        enable = 1'b0;
        color_we = we_during;
        color_in = 16'h1234;
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("reset_rgb", 16'(rgb), 16'h0000);
            chk("reset_hsync", 16'(hSync), 16'h0001);
            chk("reset_vsync", 16'(vSync), 16'h0001);
            chk("reset_tile_addr", 16'(tile_addr), 16'h0000);
            chk("reset_glyph_addr", 16'(glyph_addr), 16'h0000);
        end
        @(negedge clk);
        clear = 1'b0;
        color_we = 1'b0;
        fg_m = 8'hFF;
        bg_m = 8'h00;
        frame_m = 8'h00;
        prefill_idle();
    endtask

    // One pixel tick: enable high for a single clk, then one idle clk.
    task automatic tick(input int h, input int v, input logic b, input logic hs,
                        input logic cw = 1'b0, input logic [15:0] cv = 16'h0000);
        sb_t        e;
        int         a;
        logic [7:0] t;
        logic [7:0] g;
        logic [7:0] fg_pre, bg_pre, exp_rgb;
        @(negedge clk);
        hCount   = 11'(h);
        vCount   = 11'(v);
        bright   = b;
        hSync_in = hs;
        vSync_in = 1'b1;
        color_we = cw;
        color_in = cv;
        enable   = 1'b1;
        a = (v / 8) * 80 + (h / 8);
        t = tile_map[a];
        g = glyph_rom[{t, 3'(v % 8)}];
        e.pix    = g[7 - (h % 8)];
        e.hit    = cursor_en && (h / 8 == int'(cursor_col)) && (v / 8 == int'(cursor_row));
        e.bright = b;
        e.hs     = hs;
        e.vs     = 1'b1;
        sb.push_back(e);
        fg_pre = fg_m;
        bg_pre = bg_m;
        @(posedge clk);
        #1;
        enable   = 1'b0;
        color_we = 1'b0;
        if (cw) {fg_m, bg_m} = cv;
        tick_no++;
        if (sb.size() > 3) begin
            e = sb.pop_front();
            exp_rgb = !e.bright ? 8'h00 : ((e.pix ^ (e.hit & frame_m[4])) ? fg_pre : bg_pre);
            $display("tick %0d: rgb=%h (exp %h) hsync=%b vsync=%b", tick_no, rgb, exp_rgb, hSync, vSync);
            chk("pix_rgb", 16'(rgb), 16'(exp_rgb));
            chk("pix_hsync", 16'(hSync), 16'(e.hs));
            chk("pix_vsync", 16'(vSync), 16'(e.vs));
        end
        @(posedge clk);
    endtask

    task automatic vfall();
        @(negedge clk);
        vSync_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vSync_in = 1'b1;
        @(negedge clk);
        frame_m = frame_m + 8'd1;
    endtask

    task automatic row_pass(input int v, input int h0);
        for (int i = 0; i < 8; i++) tick(h0 + i, v, 1'b1, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) tile_map[i] = 8'($urandom);
        for (int i = 0; i < 2048; i++) glyph_rom[i] = 8'($urandom);
        tile_map[82] = 8'h41;
        glyph_rom[11'h209] = 8'b1000_0000;
        glyph_rom[11'h20A] = 8'b0000_0000;
        tile_map[0] = 8'h10;
        glyph_rom[{8'h10, 3'd0}] = 8'hFF;
        fg_m = 8'hFF;
        bg_m = 8'h00;
        frame_m = 8'h00;

        // Reset, then three flushed ticks of black with idle syncs.
        do_reset(1'b0);

        // Addressing and pixel pick.
        tick(17, 9, 1'b1, 1'b1);
        chk("tile_addr_17_9", 16'(tile_addr), 16'd82);
        tick(16, 9, 1'b1, 1'b1);
        chk("glyph_addr_41_r1", 16'(glyph_addr), 16'h0209);
        for (int i = 2; i < 8; i++) tick(16 + i, 9, 1'b1, 1'b1);

        // Blanking with an all-ones glyph and a 96-tick hSync pulse.
        for (int i = 0; i < 96; i++) tick(0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) tick(0, 0, 1'b0, 1'b1);

        // Cursor blink phases over the cell at col 2, row 1.
        cursor_en  = 1'b1;
        cursor_col = 7'd2;
        cursor_row = 6'd1;
        row_pass(10, 16);
        repeat (16) vfall();
        row_pass(10, 16);
        repeat (16) vfall();
        row_pass(10, 16);
        repeat (16) vfall();
        cursor_col = 7'd80;
        row_pass(10, 16);
        row_pass(10, 632);
        cursor_en = 1'b0;

        // Colour write landing on the tick that outputs a lit pixel.
        tick(16, 9, 1'b1, 1'b1);
        tick(17, 9, 1'b1, 1'b1);
        tick(17, 9, 1'b1, 1'b1);
        tick(16, 9, 1'b1, 1'b1, 1'b1, 16'hE003);
        tick(17, 9, 1'b1, 1'b1);
        tick(16, 9, 1'b1, 1'b1);
        tick(17, 9, 1'b1, 1'b1);
        repeat (3) tick(0, 0, 1'b0, 1'b1);
        chk("color_fg_after_write", 16'(rgb), 16'h0003);

        // Mid-frame reset with a lit pixel and hSync low in flight; colour write must lose.
        repeat (4) tick(16, 9, 1'b1, 1'b0);
        do_reset(1'b1);
        repeat (5) tick(16, 9, 1'b1, 1'b0);
        chk("post_reset_fg", 16'(rgb), 16'h00FF);
        repeat (3) tick(0, 0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
